// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD bus receiver: command codes,
// decoder state encoding and default panel geometry.
package lcd_pkg;

  localparam int DEF_H_RES = 240;
  localparam int DEF_V_RES = 320;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_DROP,
    ST_OTHER
  } lcd_state_t;

endpackage

// File: rtl/lcd_pin_sync.sv
// Brings the asynchronous LCD pins into HCLK through a synchroniser chain and
// turns a qualified WR rising edge into a single-cycle beat with its RS/DATA.
module lcd_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_cs,
  input  logic        i_rs,
  input  logic        i_wr,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  output logic        o_beat,
  output logic        o_beat_rs,
  output logic [15:0] o_beat_data,
  output logic        o_rst_n_s
);

  localparam int W = 20;
  // Idle-bus pattern {rst, cs, wr, rs, data}: CS/WR high, panel in reset, so
  // leaving HRESETn can never look like a WR edge.
  localparam logic [W-1:0] SYNC_INIT = {1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};

  logic [SYNC_STAGES*W-1:0] r_sync;
  logic                     r_wr_d;
  logic [W-1:0]             w_pins;
  logic [W-1:0]             w_last;

  assign w_pins = {i_rst, i_cs, i_wr, i_rs, i_data};
  assign w_last = r_sync[SYNC_STAGES*W-1 -: W];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync <= {SYNC_STAGES{SYNC_INIT}};
      r_wr_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[(SYNC_STAGES-1)*W-1:0], w_pins};
      r_wr_d <= w_last[17];
    end
  end

  assign o_beat      = w_last[17] & ~r_wr_d & ~w_last[18] & w_last[19];
  assign o_beat_rs   = w_last[16];
  assign o_beat_data = w_last[15:0];
  assign o_rst_n_s   = w_last[19];

endmodule

// File: rtl/lcd_8080_rx.sv
// 8080-bus command/pixel decoder: tracks the CASET/PASET window and emits
// pixel writes with raster auto-increment for a frame-buffer writer.
module lcd_8080_rx
  import lcd_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        LCD_CS,
  input  logic        LCD_RS,
  input  logic        LCD_WR,
  input  logic        LCD_RD,
  input  logic        LCD_RST,
  input  logic [15:0] LCD_DATA,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        win_err
);

  localparam logic [8:0] H_MAX = 9'(H_RES - 1);
  localparam logic [8:0] V_MAX = 9'(V_RES - 1);

  logic        w_beat, w_beat_rs, w_rst_n;
  logic [15:0] w_beat_data;
  logic        w_cmd, w_dat, w_win_ok;
  logic [7:0]  w_code;
  logic        w_unused_rd;

  lcd_state_t  r_state, w_state_next;
  logic [8:0]  r_sc, r_ec, r_sp, r_ep, r_x, r_y;
  logic [2:0]  r_pidx;
  logic        r_phi;
  logic [8:0]  r_pstart;

  lcd_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .i_cs        (LCD_CS),
    .i_rs        (LCD_RS),
    .i_wr        (LCD_WR),
    .i_rst       (LCD_RST),
    .i_data      (LCD_DATA),
    .o_beat      (w_beat),
    .o_beat_rs   (w_beat_rs),
    .o_beat_data (w_beat_data),
    .o_rst_n_s   (w_rst_n)
  );

  assign w_unused_rd = LCD_RD;
  assign w_cmd  = w_beat & ~w_beat_rs;
  assign w_dat  = w_beat &  w_beat_rs;
  assign w_code = w_beat_data[7:0];
  assign w_win_ok = (r_sc <= r_ec) && ({23'd0, r_ec} < H_RES) &&
                    (r_sp <= r_ep) && ({23'd0, r_ep} < V_RES);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!w_rst_n) begin
      w_state_next = ST_IDLE;
    end else if (w_cmd) begin
      case (w_code)
        CMD_CASET:             w_state_next = ST_CASET;
        CMD_PASET:             w_state_next = ST_PASET;
        CMD_RAMWR, CMD_RAMWRC: w_state_next = w_win_ok ? ST_RAMWR : ST_DROP;
        default:               w_state_next = ST_OTHER;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= 8'h00;
      pix_valid  <= 1'b0;
      pix_x      <= 9'd0;
      pix_y      <= 9'd0;
      pix_data   <= 16'h0000;
      frame_done <= 1'b0;
      win_err    <= 1'b0;
      r_sc       <= 9'd0;
      r_ec       <= H_MAX;
      r_sp       <= 9'd0;
      r_ep       <= V_MAX;
      r_x        <= 9'd0;
      r_y        <= 9'd0;
      r_pidx     <= 3'd0;
      r_phi      <= 1'b0;
      r_pstart   <= 9'd0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (!w_rst_n) begin
        win_err <= 1'b0;
        r_sc    <= 9'd0;
        r_ec    <= H_MAX;
        r_sp    <= 9'd0;
        r_ep    <= V_MAX;
        r_x     <= 9'd0;
        r_y     <= 9'd0;
        r_pidx  <= 3'd0;
      end else if (w_cmd) begin
        cmd_valid <= 1'b1;
        cmd_code  <= w_code;
        r_pidx    <= 3'd0;
        if (w_code == CMD_RAMWR || w_code == CMD_RAMWRC) begin
          if (!w_win_ok) begin
            win_err <= 1'b1;
          end else if (w_code == CMD_RAMWR) begin
            r_x <= r_sc;
            r_y <= r_sp;
          end
        end
      end else if (w_dat) begin
        case (r_state)
          ST_CASET, ST_PASET: begin
            // Only bit 0 of each high byte survives; the window check flags overflow.
            if (r_pidx != 3'd4) r_pidx <= r_pidx + 3'd1;
            case (r_pidx)
              3'd0, 3'd2: r_phi    <= w_beat_data[0];
              3'd1:       r_pstart <= {r_phi, w_beat_data[7:0]};
              3'd3: begin
                if (r_state == ST_CASET) begin
                  r_sc <= r_pstart;
                  r_ec <= {r_phi, w_beat_data[7:0]};
                end else begin
                  r_sp <= r_pstart;
                  r_ep <= {r_phi, w_beat_data[7:0]};
                end
              end
              default: ;
            endcase
          end
          ST_RAMWR: begin
            pix_valid <= 1'b1;
            pix_x     <= r_x;
            pix_y     <= r_y;
            pix_data  <= w_beat_data;
            if (r_x == r_ec) begin
              r_x <= r_sc;
              if (r_y == r_ep) begin
                r_y        <= r_sp;
                frame_done <= 1'b1;
              end else begin
                r_y <= r_y + 9'd1;
              end
            end else begin
              r_x <= r_x + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
